// File: rtl/kernel_pkg.sv
// Shared types and constants for the kernel multiplier scheduler.
package kernel_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 8;

   // Bits needed to index 'value' items; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_add_core.sv
// Shift-add multiplier datapath: operand latches, accumulator and iteration counter.
module shift_add_core
   import kernel_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   mcand,
   input  logic [W-1:0]   mplier,
   output logic [2*W-1:0] acc,
   output logic           last
);

   localparam int CW = clog2(W);

   logic [W-1:0]   mcand_q, mplier_q;
   logic [2*W-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q;
   logic [2*W-1:0] partial;

   // Accumulator value once the current iteration is applied.
   always_comb begin
      partial = {{W{1'b0}}, mcand_q} << cnt_q;
      acc_d   = mplier_q[cnt_q] ? (acc_q + partial) : acc_q;
   end

   // acc exposes the post-step value so the final product can be captured on the last step edge.
   assign acc  = acc_d;
   assign last = (cnt_q == CW'(W - 1));

   // Operand capture on load, one add/shift iteration per step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (load) begin
         mcand_q  <= mcand;
         mplier_q <= mplier;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (step) begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/kernel_mul_sched.sv
// Round-robin scheduler sharing one shift-add multiplier among N_REQ requesters.
module kernel_mul_sched
   import kernel_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] op_a,
   input  logic [N_REQ*W-1:0] op_b,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [2*W-1:0]     product,
   output logic               busy
);

   localparam int PW = clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]      winner_q, winner_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [2*W-1:0]     product_q, product_d;
   logic               busy_q, busy_d;

   logic               any_req;
   logic [PW-1:0]      pick;
   logic               core_load, core_step, core_last;
   logic [2*W-1:0]     core_acc;
   logic [W-1:0]       mcand_sel, mplier_sel;

   // Round-robin pick: scan offsets from the far end so the nearest requester at/after rr_ptr wins.
   always_comb begin
      int idx;
      idx     = 0;
      any_req = 1'b0;
      pick    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (req[idx]) begin
            any_req = 1'b1;
            pick    = PW'(idx);
         end
      end
   end

   assign mcand_sel  = op_a[pick*W +: W];
   assign mplier_sel = op_b[pick*W +: W];

   shift_add_core #(.W(W)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .step   (core_step),
      .mcand  (mcand_sel),
      .mplier (mplier_sel),
      .acc    (core_acc),
      .last   (core_last)
   );

   // State and output registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         winner_q  <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         winner_q  <= winner_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         product_q <= product_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state: accept in IDLE, iterate in BUSY until the last step, one DONE cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = BUSY;
         BUSY:    if (core_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath controls and next values of the registered outputs.
   always_comb begin
      core_load = 1'b0;
      core_step = 1'b0;
      winner_d  = winner_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               core_load = 1'b1;
               winner_d  = pick;
               gnt_d     = ONE << pick;
            end
         end
         BUSY: begin
            core_step = 1'b1;
            if (core_last) begin
               product_d = core_acc;
               done_d    = ONE << winner_q;
            end
         end
         DONE: begin
            gnt_d    = '0;
            rr_ptr_d = (winner_q == PW'(N_REQ - 1)) ? '0 : winner_q + PW'(1);
         end
         default: begin
            gnt_d = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign product = product_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_kernel_mul_sched.sv
// Directed plus randomized bench for kernel_mul_sched against a behavioural model.
module tb_kernel_mul_sched;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] op_a, op_b;
   logic [N-1:0]   gnt, done;
   logic [2*W-1:0] product;
   logic           busy;

   int checks   = 0;
   int failures = 0;
   int rr_model = 0;
   int cyc      = 0;

   kernel_mul_sched #(.N_REQ(N), .W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .op_a    (op_a),
      .op_b    (op_b),
      .gnt     (gnt),
      .done    (done),
      .product (product),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Winner = requester with the smallest circular distance from the pointer.
   function automatic int model_pick(input logic [N-1:0] r, input int ptr);
      int best, bestd;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         if (r[i] && (((i - ptr) + N) % N) < bestd) begin
            bestd = ((i - ptr) + N) % N;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic set_ops(input int i, input int a, input int b);
      op_a[i*W +: W] = W'(a);
      op_b[i*W +: W] = W'(b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      rr_model = 0;
   endtask

   // One full operation from an IDLE cycle with req already driven.
   task automatic run_op(input bit drop, input bit scramble, output int w_obs, output int t_acc);
      int w, exp_p;
      bit early;
      w     = model_pick(req, rr_model);
      exp_p = int'(op_a[w*W +: W]) * int'(op_b[w*W +: W]);
      tick();                                   // E0
      t_acc = cyc;
      w_obs = -1;
      for (int i = 0; i < N; i++) if (gnt[i]) w_obs = i;
      chk("gnt_accept", 32'(gnt), 32'(1) << w);
      chk("busy_accept", 32'(busy), 32'd1);
      if (scramble) begin
         op_a = {N{8'd99}};
         op_b = {N{8'd99}};
      end
      early = (done !== '0);
      for (int k = 1; k < W; k++) begin         // E1..E7
         tick();
         if (done !== '0 || gnt !== (N'(1) << w) || busy !== 1'b1) early = 1'b1;
      end
      chk("no_early_done", 32'(early), 32'd0);
      tick();                                   // E8
      chk("done_strobe", 32'(done), 32'(1) << w);
      chk("product", 32'(product), 32'(exp_p));
      chk("gnt_in_done", 32'(gnt), 32'(1) << w);
      if (drop) req[w] = 1'b0;
      tick();                                   // E9
      chk("done_cleared", 32'(done), 32'd0);
      chk("gnt_cleared", 32'(gnt), 32'd0);
      chk("busy_cleared", 32'(busy), 32'd0);
      chk("product_hold", 32'(product), 32'(exp_p));
      rr_model = (w + 1) % N;
      $display("op: winner=%0d a*b -> expected %0d got %0d at cycle %0d", w, exp_p, product, t_acc);
   endtask

   initial begin
      int w_obs, t_acc, t_prev;
      int order4 [4];
      int orderf [4];
      bit bad;
      order4 = '{0, 1, 2, 3};
      orderf = '{1, 3, 1, 3};
      rst_n = 1'b0;
      req   = '0;
      op_a  = '0;
      op_b  = '0;

      // Reset state
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single request 13*11
      set_ops(0, 13, 11);
      req = 4'b0001;
      run_op(1'b1, 1'b0, w_obs, t_acc);

      // Extremes
      set_ops(1, 255, 255);
      req = 4'b0010;
      run_op(1'b1, 1'b0, w_obs, t_acc);
      set_ops(2, 0, 200);
      req = 4'b0100;
      run_op(1'b1, 1'b0, w_obs, t_acc);
      set_ops(3, 1, 255);
      req = 4'b1000;
      run_op(1'b1, 1'b0, w_obs, t_acc);

      // All four requesting after reset
      do_reset();
      set_ops(0, 2, 3);
      set_ops(1, 4, 5);
      set_ops(2, 6, 7);
      set_ops(3, 8, 9);
      req    = 4'b1111;
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         run_op(1'b1, 1'b0, w_obs, t_acc);
         chk("rr_order", 32'(w_obs), 32'(order4[i]));
         if (i > 0) chk("accept_spacing", 32'(t_acc - t_prev), 32'd10);
         t_prev = t_acc;
      end

      // Fairness with req[1] and req[3] held
      do_reset();
      set_ops(1, 17, 3);
      set_ops(3, 5, 19);
      req = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, 1'b0, w_obs, t_acc);
         chk("fair_order", 32'(w_obs), 32'(orderf[i]));
      end
      req = '0;
      tick();

      // Operand change mid-operation
      set_ops(0, 10, 20);
      req = 4'b0001;
      run_op(1'b1, 1'b1, w_obs, t_acc);

      // Async reset during BUSY
      set_ops(1, 50, 60);
      req = 4'b0010;
      tick();                                   // E0
      chk("pre_rst_gnt", 32'(gnt), 32'd2);
      req = '0;
      for (int k = 0; k < 4; k++) tick();       // E1..E4
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_product", 32'(product), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done !== '0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("no_done_after_rst", 32'(bad), 32'd0);
      rr_model = 0;
      set_ops(2, 7, 6);
      req = 4'b0100;
      run_op(1'b1, 1'b0, w_obs, t_acc);

      // Randomized traffic
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < N; i++) set_ops(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         if (($urandom % 4) == 0) set_ops(int'($urandom % N), 0, int'($urandom_range(0, 255)));
         req = req | N'($urandom);
         if (req == '0) req[$urandom % N] = 1'b1;
         run_op(1'b1, ($urandom % 3) == 0, w_obs, t_acc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kernel_mul_sched.md
# kernel_mul_sched

Sequencer and round-robin arbiter that shares one 8x8 shift-add multiplier among several kernel compute units in the kernel-calculation stage of the downsampling processor. Each requester presents two unsigned operands with a level request. The block grants one requester at a time, latches its operands and runs the multiply as 8 add/shift iterations. It then returns the 16-bit product with a one-cycle done strobe to the granted requester.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 8: operand width; product width is 2*W.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request per requester.
- `op_a`  in  N_REQ*W  multiplicand per requester; slice i = bits [i*W +: W].
- `op_b`  in  N_REQ*W  multiplier per requester, same slicing.
- `gnt`  out  N_REQ  one-hot; high for the granted requester from acceptance until done.
- `done`  out  N_REQ  one-hot, single-cycle strobe; product valid in that cycle.
- `product`  out  2*W  unsigned result; holds its value until the next done.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Unsigned arithmetic only. The accumulator is 2*W bits wide. `product` = `op_a` * `op_b` exactly, with no overflow possible (255*255 = 65025).
- **IDLE**
  - If any `req` is high, select the winner by round-robin starting at `rr_ptr`.
  - On that clock edge: latch op_a/op_b of the winner, set `gnt[winner]`, clear acc, set cnt=0, go to BUSY.
- **BUSY**
  - On each edge: if mplier[cnt] = 1, acc += mcand << cnt; then cnt++.
  - After the edge with cnt = W-1, go to DONE and load `product` from the final acc.
- **DONE**
  - `done[winner]` = 1 for this cycle.
  - On the next edge: clear `gnt`, set `rr_ptr` = winner+1 (mod N_REQ), return to IDLE.
- `req` is sampled only in IDLE. Requests that rise or fall during BUSY/DONE have no effect on the current operation.
- Operands are sampled only at the acceptance edge. Later changes on op_a/op_b are ignored.
- A requester must drop `req` in the done cycle. If `req` is still high in the following IDLE cycle, it counts as a new request and competes normally.
- Operands of zero still take the full fixed latency. There is no early termination.
- Simultaneous requests: the lowest index at or after `rr_ptr` (with wrap-around) wins. Losing requesters keep waiting. Each requester waits at most N_REQ-1 operations.
- Reset (async, any state):
  - state = IDLE.
  - gnt = 0, done = 0, product = 0, busy = 0.
  - rr_ptr = 0, acc = 0, cnt = 0.
  - An operation in flight is discarded and no done is issued.

## Timing
- Acceptance edge E0 → BUSY for edges E1..EW (W iterations).
- DONE is the cycle after edge EW. `done` and `product` are valid in that cycle.
- Edge E(W+1) returns to IDLE.
- The earliest next acceptance is edge E(W+2). Throughput is one operation per W+2 = 10 cycles.
- `gnt` rises after E0 and falls after E(W+1).
- `busy` is high from after E0 to after E(W+1).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `kernel_pkg`:
  - State enum: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
  - Default constants N_REQ_DEF = 4, W_DEF = 8.
  - Counter width function clog2(W).
- One sub-module `shift_add_core`:
  - Holds the operand registers, accumulator and iteration counter.
  - Ports: clk, rst_n, load, step, mcand, mplier, acc, last.
- The top level holds the FSM, the round-robin picker and the gnt/done/product registers.

## Test plan
- Single request: req[0], op_a = 13, op_b = 11.
  - gnt[0] rises after E0.
  - done[0] pulses exactly one cycle, after edge E8, with product = 143.
  - busy low again after E9.
- Extremes:
  - 255*255 → 65025.
  - 0*200 → 0, still with done after E8.
  - 1*255 → 255.
- All four req high after reset and held; each requester drops its req in its done cycle:
  - Grant order is 0, 1, 2, 3.
  - Products match per-requester operands (e.g. 2*3 = 6, 4*5 = 20, 6*7 = 42, 8*9 = 72).
  - Acceptances are 10 cycles apart.
- Fairness: req[1] held permanently high with req[3] also high, starting with rr_ptr = 0.
  - Grants alternate 1, 3, 1, 3.
  - No requester waits more than one operation.
- Operand change mid-op: accept 10*20, then change op_a/op_b to 99/99 during BUSY.
  - Product is 200.
- Async reset asserted during BUSY (after E4):
  - All outputs go to 0 immediately and no done is issued.
  - After release, req[2] with 7*6 is granted (rr_ptr = 0, no other requests) and yields 42.
